// File: rtl/instruction_fetch.sv
// Fetch unit: one outstanding word request, static JAL follow, 2^QUEUE_WIDTH-entry {pc,inst} queue to decode.
// Request is combinational from IDLE; a response is visible to decode the next cycle; rdy_in low freezes all state.
module instruction_fetch #(
  parameter int          QUEUE_WIDTH = 2,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        clear,
  input  logic [31:0] clear_pc,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_valid,
  input  logic [31:0] mem_data,
  input  logic        from_dec,
  output logic        to_dec,
  output logic [31:0] to_dec_pc,
  output logic [31:0] to_dec_inst
);

  localparam int DEPTH = 1 << QUEUE_WIDTH;
  localparam logic [QUEUE_WIDTH-1:0] PTR_ONE  = 1;
  localparam logic [QUEUE_WIDTH:0]   CNT_ONE  = 1;
  localparam logic [QUEUE_WIDTH:0]   CNT_FULL = {1'b1, {QUEUE_WIDTH{1'b0}}};

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DROP = 2'd2;

  logic [1:0]             state_q, state_d;
  logic [31:0]            fetch_pc_q, fetch_pc_d;
  logic [31:0]            addr_q;
  logic [QUEUE_WIDTH-1:0] head_q, tail_q;
  logic [QUEUE_WIDTH:0]   count_q, count_d;
  logic [31:0]            pc_mem_q   [DEPTH];
  logic [31:0]            inst_mem_q [DEPTH];

  logic                   pop, push, is_jal;
  logic [QUEUE_WIDTH:0]   count_after_pop;
  logic [31:0]            jal_off, next_pc;

  assign to_dec      = (count_q != '0);
  assign to_dec_pc   = pc_mem_q[head_q];
  assign to_dec_inst = inst_mem_q[head_q];

  assign pop  = rdy_in && !clear && to_dec && from_dec;
  assign push = rdy_in && !clear && (state_q == S_WAIT) && mem_valid;

  // Free space is judged after this cycle's pop so a full queue refills without a bubble.
  assign count_after_pop = count_q - (pop ? CNT_ONE : '0);
  assign mem_req  = !rst_in && rdy_in && !clear && (state_q == S_IDLE) && (count_after_pop != CNT_FULL);
  assign mem_addr = mem_req ? fetch_pc_q : addr_q;

  assign is_jal  = (mem_data[6:0] == 7'b1101111);
  assign jal_off = {{11{mem_data[31]}}, mem_data[31], mem_data[19:12], mem_data[20], mem_data[30:21], 1'b0};
  assign next_pc = is_jal ? fetch_pc_q + jal_off : fetch_pc_q + 32'd4;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    count_d    = count_q + (push ? CNT_ONE : '0) - (pop ? CNT_ONE : '0);
    if (clear) begin
      fetch_pc_d = clear_pc;
      count_d    = '0;
      // A response landing in the flush cycle is the outstanding one; nothing left to drop.
      if (state_q != S_IDLE) state_d = mem_valid ? S_IDLE : S_DROP;
    end else begin
      case (state_q)
        S_IDLE:  if (mem_req) state_d = S_WAIT;
        S_WAIT:  if (mem_valid) begin
                   state_d    = S_IDLE;
                   fetch_pc_d = next_pc;
                 end
        S_DROP:  if (mem_valid) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      addr_q     <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]   <= '0;
        inst_mem_q[i] <= '0;
      end
    end else if (rdy_in) begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      if (mem_req) addr_q <= fetch_pc_q;
      if (clear) begin
        head_q <= '0;
        tail_q <= '0;
      end else begin
        if (pop) head_q <= head_q + PTR_ONE;
        if (push) begin
          pc_mem_q[tail_q]   <= fetch_pc_q;
          inst_mem_q[tail_q] <= mem_data;
          tail_q             <= tail_q + PTR_ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: memory responder, decoder driver and a queue-level reference model.
module tb_instruction_fetch;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, clear, mem_valid, from_dec;
  logic [31:0] clear_pc, mem_data;
  logic        mem_req, to_dec;
  logic [31:0] mem_addr, to_dec_pc, to_dec_inst;

  instruction_fetch #(.QUEUE_WIDTH(2), .RESET_PC(32'h0000_0000)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear), .clear_pc(clear_pc),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_valid(mem_valid), .mem_data(mem_data),
    .from_dec(from_dec), .to_dec(to_dec), .to_dec_pc(to_dec_pc), .to_dec_inst(to_dec_inst)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t        q[$];
  logic [31:0] progmem [256];
  int          checks = 0;
  int          errors = 0;

  // reference model of the fetch side
  logic [31:0] m_pc, m_req_addr;
  bit          m_busy, m_drop;
  // memory responder
  bit          pend;
  logic [31:0] pend_addr;
  int          wait_cnt, lat;
  bit          rand_lat;
  // per-cycle stimulus knobs
  bit          k_rdy, k_fd, k_clr;
  logic [31:0] k_clr_pc;
  // observations from the last cycle
  bit          o_req, o_to_dec;
  logic [31:0] o_addr, o_pc, o_inst;
  logic [31:0] reqs[$], popped_pc[$], popped_inst[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] next_pc(input logic [31:0] pc, input logic [31:0] w);
    logic signed [20:0] imm;
    if (w[6:0] != 7'b1101111) return pc + 32'd4;
    imm = {w[31], w[19:12], w[20], w[30:21], 1'b0};
    return pc + 32'(int'(imm));
  endfunction

  task automatic cyc();
    bit          pop, exp_req, mv;
    logic [31:0] md;
    ent_t        e;
    @(negedge clk_in);
    mv = pend && k_rdy && (wait_cnt == 0);
    md = mv ? progmem[pend_addr[9:2]] : 32'h0;
    rst_in = 1'b0; rdy_in = k_rdy; from_dec = k_fd; clear = k_clr; clear_pc = k_clr_pc;
    mem_valid = mv; mem_data = md;
    #1;
    o_req = mem_req; o_addr = mem_addr; o_to_dec = to_dec; o_pc = to_dec_pc; o_inst = to_dec_inst;
    pop     = k_rdy && k_fd && (q.size() != 0);
    exp_req = k_rdy && !k_clr && !m_busy && ((q.size() - int'(pop)) < 4);
    chk("to_dec", {31'b0, o_to_dec}, {31'b0, q.size() != 0});
    if (q.size() != 0) begin
      chk("head_pc", o_pc, q[0].pc);
      chk("head_inst", o_inst, q[0].inst);
    end
    chk("mem_req", {31'b0, o_req}, {31'b0, exp_req});
    if (exp_req) chk("req_addr", o_addr, m_pc);
    else if (m_busy) chk("held_addr", o_addr, m_req_addr);
    if (k_rdy && k_fd && o_to_dec) begin
      popped_pc.push_back(o_pc);
      popped_inst.push_back(o_inst);
    end
    if (k_rdy && o_req) reqs.push_back(o_addr);
    @(posedge clk_in);
    if (mv) pend = 1'b0;
    else if (pend && k_rdy) wait_cnt--;
    if (k_rdy && o_req) begin
      pend      = 1'b1;
      pend_addr = o_addr;
      wait_cnt  = rand_lat ? int'($urandom_range(3, 0)) : lat - 1;
    end
    if (k_rdy) begin
      if (k_clr) begin
        q.delete();
        m_pc = k_clr_pc;
        if (m_busy) begin
          m_busy = !mv;
          m_drop = m_busy;
        end
      end else begin
        if (pop) void'(q.pop_front());
        if (mv && m_busy) begin
          if (!m_drop) begin
            e.pc = m_req_addr; e.inst = md;
            q.push_back(e);
            m_pc = next_pc(m_req_addr, md);
          end
          m_busy = 1'b0;
          m_drop = 1'b0;
        end
        if (exp_req) begin
          m_busy     = 1'b1;
          m_req_addr = m_pc;
        end
      end
    end
  endtask

  initial begin
    logic [31:0] w;
    logic [31:0] exp_a [6];
    int          n0;

    rst_in = 1'b1; rdy_in = 1'b1; clear = 1'b0; clear_pc = '0;
    mem_valid = 1'b0; mem_data = '0; from_dec = 1'b0;
    for (int i = 0; i < 256; i++) begin
      w = $urandom;
      if ($urandom_range(3, 0) == 0) w[6:0] = 7'b1101111;
      else if (w[6:0] == 7'b1101111) w[0] = 1'b0;
      progmem[i] = w;
    end
    for (int i = 0; i < 4; i++) progmem[i] = 32'h0000_0013;
    progmem[4] = 32'h0100_006F;
    m_pc = '0; m_req_addr = '0; m_busy = 0; m_drop = 0;
    pend = 0; pend_addr = '0; wait_cnt = 0; lat = 1; rand_lat = 0;
    k_rdy = 1; k_fd = 1; k_clr = 0; k_clr_pc = '0;

    // reset state
    repeat (3) @(posedge clk_in);
    #1;
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_to_dec", {31'b0, to_dec}, 32'd0);

    // sequential fetch then JAL at 0x10
    repeat (16) cyc();
    exp_a = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h20};
    for (int i = 0; i < 6; i++) chk("seq_req_addr", reqs[i], exp_a[i]);
    for (int i = 0; i < 5; i++) chk("seq_pop_pc", popped_pc[i], exp_a[i]);
    for (int i = 0; i < 4; i++) chk("seq_pop_inst", popped_inst[i], 32'h0000_0013);
    chk("jal_pop_inst", popped_inst[4], 32'h0100_006F);

    // full queue
    k_fd = 0; k_clr = 1; k_clr_pc = 32'h200; cyc(); k_clr = 0;
    n0 = reqs.size();
    repeat (20) cyc();
    chk("full_req_count", reqs.size() - n0, 32'd4);
    chk("full_head_pc", o_pc, 32'h200);
    chk("full_no_req", {31'b0, o_req}, 32'd0);
    n0 = reqs.size();
    k_fd = 1; cyc(); k_fd = 0;
    repeat (8) cyc();
    chk("one_pop_one_req", reqs.size() - n0, 32'd1);

    // clear while waiting on memory
    lat = 3; k_fd = 1; n0 = reqs.size();
    for (int i = 0; i < 10 && reqs.size() == n0; i++) cyc();
    chk("wait_req_seen", reqs.size() - n0, 32'd1);
    k_fd = 0;
    progmem[pend_addr[9:2]] = 32'hDEAD_BEEF;
    k_clr = 1; k_clr_pc = 32'h100; cyc(); k_clr = 0;
    chk("clr_no_req", {31'b0, o_req}, 32'd0);
    cyc(); chk("clr_flushed", {31'b0, o_to_dec}, 32'd0);
    cyc(); chk("drop_not_queued", {31'b0, o_to_dec}, 32'd0);
    cyc();
    chk("redirect_req", {31'b0, o_req}, 32'd1);
    chk("redirect_addr", o_addr, 32'h100);

    // clear coinciding with pop and response
    lat = 2;
    for (int i = 0; i < 40 && !(q.size() == 2 && pend && wait_cnt == 0); i++) cyc();
    chk("cpv_setup", {31'b0, q.size() == 2 && pend && wait_cnt == 0}, 32'd1);
    k_fd = 1; k_clr = 1; k_clr_pc = 32'h500; cyc(); k_clr = 0; k_fd = 0;
    cyc();
    chk("cpv_empty", {31'b0, o_to_dec}, 32'd0);
    chk("cpv_req", {31'b0, o_req}, 32'd1);
    chk("cpv_addr", o_addr, 32'h500);

    // rdy_in low freezes everything
    lat = 1; k_clr = 1; k_clr_pc = 32'h600; cyc(); k_clr = 0;
    for (int i = 0; i < 30 && q.size() < 2; i++) cyc();
    k_rdy = 0; k_fd = 1;
    repeat (3) begin
      cyc();
      chk("frz_no_req", {31'b0, o_req}, 32'd0);
      chk("frz_head_pc", o_pc, 32'h600);
    end
    n0 = popped_pc.size();
    k_rdy = 1; cyc();
    chk("resume_pop_pc", popped_pc[n0], 32'h600);
    repeat (10) cyc();

    // random traffic
    rand_lat = 1;
    repeat (500) begin
      k_rdy    = ($urandom_range(9, 0) != 0);
      k_fd     = ($urandom_range(2, 0) != 0);
      k_clr    = k_rdy && ($urandom_range(29, 0) == 0);
      k_clr_pc = 32'($urandom) & 32'hFFFF_FFFC;
      cyc();
    end
    k_clr = 0; k_rdy = 1;
    repeat (10) cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction fetch unit with a small instruction queue, directly upstream of the decoder. It requests 32-bit instruction words from the memory controller one at a time, follows `JAL` targets statically and otherwise predicts pc+4. It buffers fetched {pc, instruction} pairs and presents them to the decoder under a valid/ready handshake. A ROB-driven `clear` flushes everything and redirects fetch to `clear_pc`.

## Interface

- `QUEUE_WIDTH`, default 2: log2 of queue depth (depth = 4).
- `RESET_PC`, default 32'h0000_0000: fetch address after reset.

- `clk_in` input 1: clock; all state updates on the rising edge.
- `rst_in` input 1: reset, synchronous, active-high.
- `rdy_in` input 1: global enable; when low, all state holds and `mem_req` is 0.
- `clear` input 1: mispredict flush from the ROB.
- `clear_pc` input 32: redirect target, sampled when `clear` is 1.
- `mem_req` output 1: single-cycle fetch request pulse.
- `mem_addr` output 32: fetch address, held stable from `mem_req` until `mem_valid`.
- `mem_valid` input 1: response strobe; one per request; never asserted while `rdy_in` is 0.
- `mem_data` input 32: instruction word, valid with `mem_valid`.
- `from_dec` input 1: decoder ready (the decoder's `to_if`).
- `to_dec` output 1: queue head valid (the decoder's `from_if`).
- `to_dec_pc` output 32: pc of head entry.
- `to_dec_inst` output 32: instruction of head entry.

## Operation

**Queue**
- Circular buffer of {pc, inst}, depth 2^QUEUE_WIDTH.
- Registers: head, tail (QUEUE_WIDTH bits, wrap naturally) and count (QUEUE_WIDTH+1 bits).
- `to_dec` = (count != 0). `to_dec_pc` and `to_dec_inst` are read combinationally from the head entry.
- Pop when `to_dec && from_dec` at a clock edge.
- Push on an accepted `mem_valid` in state WAIT.
- Simultaneous push and pop: count is unchanged and both pointers advance.

**FSM** (states IDLE, WAIT, DROP)
- **IDLE:** if count < depth, assert `mem_req` and drive `mem_addr` = fetch_pc, then go to WAIT. Count is checked after any same-cycle pop. Because only one request is ever outstanding, a push can never overflow.
- **WAIT:** on `mem_valid`:
  - Push {fetch_pc, mem_data}.
  - If `mem_data[6:0]` == 7'b1101111 (JAL), set fetch_pc to fetch_pc + sext({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}). Otherwise set fetch_pc to fetch_pc + 4.
  - All address arithmetic is 32-bit with wrap.
  - Go to IDLE.
- **DROP:** wait for `mem_valid`, discard the data without pushing or updating fetch_pc, then go to IDLE.

**Clear** (highest priority below reset)
- Sets count = 0, head = tail = 0, fetch_pc = `clear_pc`.
- Any same-cycle pop or push is discarded.
- No `mem_req` is issued in the clear cycle.
- State transitions:
  - IDLE stays IDLE.
  - WAIT goes to DROP, even if `mem_valid` arrives in the same cycle; that response is then treated as already dropped and the state goes to IDLE instead.
  - DROP stays DROP, with fetch_pc updated.

**Reset and enable**
- Reset values: fetch_pc = RESET_PC, state IDLE, head = tail = count = 0, `mem_req` = 0, `mem_addr` = 0, `to_dec` = 0. Reset overrides `rdy_in`.
- Reset mid-WAIT goes to IDLE. The memory controller is reset by the same signal, so no stale response is expected.
- `rdy_in` = 0 freezes the FSM, queue and fetch_pc.

## Timing

- Request at edge T (`mem_req` high in cycle T).
- Response earliest in cycle T+1. Entry pushed at the end of that cycle; `to_dec` high in cycle T+2 if the queue was empty.
- The next request is issued in the cycle after the push. Steady-state throughput is one word per (memory latency + 1) cycles.
- Decoder handshake: the decoder samples `to_dec`, `to_dec_pc` and `to_dec_inst` at the edge where `from_dec` = 1. The head advances at that edge.
- `clear` at edge E: `to_dec` = 0 in cycle E+1. The first request to `clear_pc` is in cycle E+1 if the state is IDLE; otherwise it follows the dropped response.

## Test plan

- **Reset then fetch:** reset, memory returns 32'h00000013 after 1 cycle, `from_dec` = 1 → `mem_addr` 0, 4, 8…; `to_dec_pc` sequence 0, 4, 8 with `to_dec_inst` = 32'h00000013.
- **JAL follow:** word at pc 0x10 is 32'h0100006F (jal x0, +16) → next `mem_addr` = 0x20; queue holds {0x10, 32'h0100006F}.
- **Full queue:** `from_dec` = 0 → exactly 4 requests are issued, count = 4, `mem_req` stays 0. Raise `from_dec` for one cycle → exactly one new request.
- **Clear during WAIT:** `clear` = 1 with `clear_pc` = 0x100 while waiting; response 32'hDEADBEEF arrives 2 cycles later → not enqueued, `to_dec` = 0, next `mem_addr` = 0x100.
- **Clear with simultaneous pop and `mem_valid`:** count = 2, `from_dec` = 1, `mem_valid` = 1 and `clear` = 1 in the same cycle → count = 0, state IDLE, next request at `clear_pc`.
- **`rdy_in` low:** deassert for 3 cycles with the queue non-empty and `from_dec` = 1 → no pops, no `mem_req`, fetch_pc unchanged; resumes exactly where it stopped.
